led_messenger: RTL and testbench
================================

Name: led_messenger

Overview:
- Drives a WS2812 (NeoPixel) strip with a scrolling text message.
- Shows one ASCII character at a time as its 8-bit code: a lit LED means a 1 bit.
- A debounced push-button cycles the display colour.
- Top-level leaf: one clock, one button input, one serial data output to the strip.

Parameters:
- CLK_FREQ, 12_000_000, system clock frequency in Hz; all timing constants derive from it.
- NUM_LEDS, 8, LEDs per strip (1..16); 24 bits sent per LED each frame.
- MSG_LEN, 8, message characters used (1..16), taken from the start of the message ROM.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- btn_color  input  1  colour button, active-high, asynchronous to clk.
- led_data  output  1  WS2812 serial data, registered.

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-low.
- During reset: led_data=0, char index=0, colour mode=0, bit/LED counters=0, debounce lockout clear.
- FSM state after reset = LATCH.

Derived timing constants, in cycles (integer division, then clamped):
- T0H = max(1, CLK_FREQ/2_500_000).
- T1H = max(T0H+1, CLK_FREQ/1_250_000). T1H > T0H is guaranteed, so bits decode at any clock.
- T0L = max(1, CLK_FREQ/1_250_000).
- T1L = max(1, CLK_FREQ/2_500_000).
- TRESET = max(50, CLK_FREQ/16_000), at least 62.5 µs at normal rates.
- TSTEP = CLK_FREQ/4, i.e. 250 ms per character.
- TDEB = CLK_FREQ/100, i.e. 10 ms lockout.
- At 1 MHz these give T0H=1, T1H=2, T0L=1, T1L=1, TRESET=62.

FSM states LATCH, LOAD, HIGH, LOW:
- LATCH: led_data=0 for TRESET cycles, then go to LOAD.
- LOAD: at LED 0, snapshot colour mode and char index so the whole frame is consistent. Build the 24-bit GRB word for the current LED. Go to HIGH.
- HIGH: led_data=1 for T1H cycles if the current bit is 1, else T0H. Go to LOW.
- LOW: led_data=0 for T1L or T0L cycles. Then:
  - next bit, back to HIGH; or
  - after bit 0, next LED via LOAD; or
  - after the last LED, back to LATCH.
- Bit order: MSB first, G[7:0], then R[7:0], then B[7:0].
- Frames repeat continuously. Frame length = NUM_LEDS×24 bits plus TRESET.

LED content:
- Message ROM, 16 chars: "HELLO FAB FUTURE". Character k = ROM[k], k < MSG_LEN.
- LED i (i=0 is the first LED sent) is lit when i<8 and bit (7−i) of the current char is 1. Otherwise the LED is 00/00/00.
- Lit colour by mode, as G/R/B:
  - 0 = red 00/20/00.
  - 1 = green 20/00/00.
  - 2 = blue 00/00/20.
  - 3 = white 20/20/20.

Character step:
- Free-running counter, period TSTEP.
- On expiry, char index increments and wraps from MSG_LEN−1 to 0.
- Takes effect at the next frame's LOAD of LED 0.

Button:
- 2-flop synchroniser, then rising-edge detect.
- An edge seen while lockout is clear:
  - increments colour mode (3 wraps to 0);
  - starts a TDEB lockout.
- Edges during lockout are ignored.
- A 1-cycle pulse after synchronisation is accepted, so a 20 µs press registers.
- Holding the button produces exactly one increment.
- A new mode shows from the next frame start; a frame in flight is never altered.

Reset mid-frame: led_data drops to 0 immediately. The restart begins with a full LATCH period.

Test Plan:
1. CLK_FREQ=1e6, NUM_LEDS=8, MSG_LEN=8; release reset.
   - led_data stays low for 62 µs.
   - First frame decodes (HIGH >0.6 µs = 1) as char 'H'=0x48.
   - LEDs 1 and 4 read G=00 R=20 B=00; all others 00/00/00.
   - 192 bits per frame.
2. Same setup, measure timing.
   - Every 0-bit is 1 cycle high + 1 low; every 1-bit is 2 high + 1 low.
   - Gap between frames ≥ 62 cycles low.
   - Frames repeat within 5 ms.
3. Press btn_color for 20 µs at t≈5 ms.
   - The next frame after the press shows lit LEDs as G=20 R=00 B=00.
   - The frame in flight is unchanged.
4. Two presses 2 ms apart (inside TDEB): only one mode increment. A third press after 15 ms moves to blue 00/00/20. Four accepted presses return to red.
5. Run to TSTEP expiry (250 ms at 1 MHz).
   - The next frame shows 'E'=0x45: LEDs 1, 5, 7 lit.
   - After 8 steps the display returns to 'H'.
6. Assert rst_n low mid-frame.
   - led_data goes 0 at once; colour mode returns to red and char to 'H'.
   - After release, a full 62-cycle latch precedes a clean frame.

Source files
------------

// File: rtl/led_messenger.sv
// led_messenger: drives a WS2812 strip with a scrolling message, one
// character per frame shown as its 8-bit code (lit LED = 1 bit), MSB on LED 0.
// A debounced button cycles the lit colour: red, green, blue, white.
module led_messenger #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int NUM_LEDS = 8,
  parameter int MSG_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_color,
  output logic led_data
);

  // Bit timing in clock cycles, clamped so every phase lasts at least one
  // cycle and a 1-bit is always longer high than a 0-bit.
  localparam int T0H_RAW    = CLK_FREQ / 2_500_000;
  localparam int T0H        = (T0H_RAW < 1) ? 1 : T0H_RAW;
  localparam int T1H_RAW    = CLK_FREQ / 1_250_000;
  localparam int T1H        = (T1H_RAW < T0H + 1) ? T0H + 1 : T1H_RAW;
  localparam int T0L        = (T1H_RAW < 1) ? 1 : T1H_RAW;
  localparam int T1L        = T0H;
  localparam int TRESET_RAW = CLK_FREQ / 16_000;
  localparam int TRESET     = (TRESET_RAW < 50) ? 50 : TRESET_RAW;
  localparam int TSTEP      = (CLK_FREQ / 4 < 1) ? 1 : CLK_FREQ / 4;
  localparam int TDEB       = CLK_FREQ / 100;

  // TRESET is always the longest serialiser phase, so it sizes the timer.
  localparam int TW = $clog2(TRESET + 1);
  localparam int SW = $clog2(TSTEP + 1);
  localparam int DW = $clog2(TDEB + 2);
  localparam int LW = 5;

  localparam logic [1:0] ST_LATCH = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  // Message ROM: "HELLO FAB FUTURE"
  function automatic logic [7:0] msg_rom(input logic [3:0] k);
    logic [7:0] c;
    case (k)
      4'd0:    c = 8'h48;
      4'd1:    c = 8'h45;
      4'd2:    c = 8'h4C;
      4'd3:    c = 8'h4C;
      4'd4:    c = 8'h4F;
      4'd5:    c = 8'h20;
      4'd6:    c = 8'h46;
      4'd7:    c = 8'h41;
      4'd8:    c = 8'h42;
      4'd9:    c = 8'h20;
      4'd10:   c = 8'h46;
      4'd11:   c = 8'h55;
      4'd12:   c = 8'h54;
      4'd13:   c = 8'h55;
      4'd14:   c = 8'h52;
      4'd15:   c = 8'h45;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // GRB word for one LED: LED i shows bit (7-i) of the character.
  function automatic logic [23:0] pixel_word(input logic [LW-1:0] idx,
                                             input logic [7:0] ch,
                                             input logic [1:0] mode);
    logic        lit;
    logic [23:0] col;
    if (idx < 5'd8) begin
      lit = ch[3'd7 - idx[2:0]];
    end else begin
      lit = 1'b0;
    end
    case (mode)
      2'd0:    col = 24'h00_20_00;
      2'd1:    col = 24'h20_00_00;
      2'd2:    col = 24'h00_00_20;
      2'd3:    col = 24'h20_20_20;
      default: col = 24'h00_00_00;
    endcase
    return lit ? col : 24'h00_00_00;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    bit_q, bit_d;
  logic [LW-1:0] led_q, led_d;
  logic [23:0]   word_q, word_d;
  logic [3:0]    fchar_q, fchar_d;
  logic [1:0]    fmode_q, fmode_d;
  logic          led_data_q;

  logic [3:0]    char_q;
  logic [1:0]    mode_q;
  logic [SW-1:0] step_q;
  logic [DW-1:0] deb_q;
  logic [1:0]    sync_q;
  logic          btn_prev_q;

  logic [23:0]   pix_s;
  logic          cur_bit_s, next_bit_s, last_led_s, led_end_s;
  logic [TW-1:0] low_len_s;
  logic          btn_edge_s, lockout_s;

  // Frame serialiser next state; the LOAD cycle doubles as the last low
  // cycle of the previous bit so LED boundaries keep exact bit timing.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_d      = bit_q;
    led_d      = led_q;
    word_d     = word_q;
    fchar_d    = fchar_q;
    fmode_d    = fmode_q;
    if (led_q == 5'd0) begin
      pix_s = pixel_word(led_q, msg_rom(char_q), mode_q);
    end else begin
      pix_s = pixel_word(led_q, msg_rom(fchar_q), fmode_q);
    end
    cur_bit_s  = word_q[bit_q];
    next_bit_s = word_q[bit_q - 5'd1];
    last_led_s = (led_q == LW'(NUM_LEDS - 1));
    led_end_s  = (bit_q == 5'd0) && !last_led_s;
    low_len_s  = cur_bit_s ? TW'(T1L) : TW'(T0L);
    case (state_q)
      ST_LATCH: begin
        if (tmr_q == TW'(0)) begin
          state_d = ST_LOAD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_LOAD: begin
        if (led_q == 5'd0) begin
          fchar_d = char_q;
          fmode_d = mode_q;
        end else begin
          fchar_d = fchar_q;
          fmode_d = fmode_q;
        end
        word_d  = pix_s;
        bit_d   = 5'd23;
        tmr_d   = pix_s[23] ? TW'(T1H - 1) : TW'(T0H - 1);
        state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (tmr_q != TW'(0)) begin
          tmr_d = tmr_q - TW'(1);
        end else if (led_end_s && low_len_s == TW'(1)) begin
          led_d   = led_q + 5'd1;
          state_d = ST_LOAD;
        end else if (led_end_s) begin
          tmr_d   = low_len_s - TW'(2);
          state_d = ST_LOW;
        end else begin
          tmr_d   = low_len_s - TW'(1);
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tmr_q != TW'(0)) begin
          tmr_d = tmr_q - TW'(1);
        end else if (bit_q != 5'd0) begin
          bit_d   = bit_q - 5'd1;
          tmr_d   = next_bit_s ? TW'(T1H - 1) : TW'(T0H - 1);
          state_d = ST_HIGH;
        end else if (last_led_s) begin
          led_d   = 5'd0;
          tmr_d   = TW'(TRESET - 1);
          state_d = ST_LATCH;
        end else begin
          led_d   = led_q + 5'd1;
          state_d = ST_LOAD;
        end
      end
      default: begin
        led_d   = 5'd0;
        tmr_d   = TW'(TRESET - 1);
        state_d = ST_LATCH;
      end
    endcase
  end

  // Serialiser registers; output is high exactly while the FSM is in HIGH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LATCH;
      tmr_q      <= TW'(TRESET - 1);
      bit_q      <= 5'd0;
      led_q      <= 5'd0;
      word_q     <= 24'h00_00_00;
      fchar_q    <= 4'd0;
      fmode_q    <= 2'd0;
      led_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      led_q      <= led_d;
      word_q     <= word_d;
      fchar_q    <= fchar_d;
      fmode_q    <= fmode_d;
      led_data_q <= (state_d == ST_HIGH);
    end
  end

  // Free-running character step timer; the new index is picked up at the
  // next frame's first LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= SW'(0);
      char_q <= 4'd0;
    end else if (step_q == SW'(TSTEP - 1)) begin
      step_q <= SW'(0);
      char_q <= (char_q == 4'(MSG_LEN - 1)) ? 4'd0 : char_q + 4'd1;
    end else begin
      step_q <= step_q + SW'(1);
      char_q <= char_q;
    end
  end

  assign btn_edge_s = sync_q[1] & ~btn_prev_q;
  assign lockout_s  = (deb_q != DW'(0));

  // Button synchroniser, edge detect and lockout-debounced colour counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      btn_prev_q <= 1'b0;
      deb_q      <= DW'(0);
      mode_q     <= 2'd0;
    end else begin
      sync_q     <= {sync_q[0], btn_color};
      btn_prev_q <= sync_q[1];
      if (btn_edge_s && !lockout_s) begin
        mode_q <= mode_q + 2'd1;
        deb_q  <= DW'(TDEB);
      end else if (lockout_s) begin
        mode_q <= mode_q;
        deb_q  <= deb_q - DW'(1);
      end else begin
        mode_q <= mode_q;
        deb_q  <= deb_q;
      end
    end
  end

  assign led_data = led_data_q;

endmodule

// File: tb/tb_led_messenger.sv
// Bench for led_messenger. Runs at CLK_FREQ=20_000 so bit timing matches the
// 1 MHz case (T0H=1, T1H=2, T0L=1, T1L=1) while TRESET clamps to 50,
// TSTEP=5000 and TDEB=200 cycles keep the run short.
`timescale 1ns/1ps
module tb_led_messenger;

  localparam int STEP = 5000;
  localparam int GAP  = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_color;
  logic led_data;

  led_messenger #(.CLK_FREQ(20_000), .NUM_LEDS(8), .MSG_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_color(btn_color), .led_data(led_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int frames_done = 0;
  int to_cnt = 0;
  int to_seen = 0;
  int cyc;

  logic [9:0] exp_q[$];

  // Cycles since reset release, used to know which character is showing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [7:0] msg_char(input int k);
    case (k)
      0: return 8'h48; 1: return 8'h45; 2: return 8'h4C; 3: return 8'h4C;
      4: return 8'h4F; 5: return 8'h20; 6: return 8'h46; 7: return 8'h41;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [191:0] exp_frame(input logic [7:0] ch, input logic [1:0] md);
    logic [191:0] f;
    logic [23:0] col;
    case (md)
      2'd0: col = 24'h002000;
      2'd1: col = 24'h200000;
      2'd2: col = 24'h000020;
      default: col = 24'h202020;
    endcase
    f = '0;
    for (int i = 0; i < 8; i++) f = {f[167:0], (ch[7 - i] ? col : 24'h000000)};
    return f;
  endfunction

  // Monitor: decodes the serial stream, pops an expectation at each frame
  // start and checks the frame contents and bit timing when it completes.
  int low_run = 0, high_run = 0, nbits = 0, timing_err = 0, extra_bits = 0;
  bit prev = 0, collecting = 0, armed = 0, post_pending = 0, in_rst = 0;
  logic [9:0] cur;
  logic [191:0] got_bits, want;

  always @(negedge clk) begin
    if (to_cnt != to_seen) begin
      to_seen = to_cnt;
      checks++; fails++;
      $display("FAIL wait_timeout: got=%0d timeouts required=0", to_cnt);
    end
    if (!rst_n) begin
      if (!in_rst) begin
        checks++;
        if (led_data !== 1'b0) begin
          fails++;
          $display("FAIL reset_low: got=%b required=0", led_data);
        end
      end
      in_rst = 1; low_run = 0; high_run = 0; prev = 0; collecting = 0;
      armed = 0; post_pending = 0; nbits = 0;
    end else begin
      in_rst = 0;
      if (led_data === 1'b1) begin
        if (!prev) begin
          if (low_run >= GAP) begin
            if (post_pending) begin
              checks++;
              if (extra_bits != 0) begin
                fails++;
                $display("FAIL extra_bits: got=%0d required=0", extra_bits);
              end
              post_pending = 0;
            end
            if (armed) begin
              checks++; fails++;
              $display("FAIL short_frame: got=%0d bits required=192", nbits);
              armed = 0;
            end
            collecting = 1; nbits = 0; timing_err = 0; got_bits = '0;
            if (exp_q.size() > 0) begin
              cur = exp_q.pop_front();
              armed = 1;
            end
          end else begin
            if (collecting && low_run != 1) timing_err++;
            if (!collecting) extra_bits++;
          end
          high_run = 0;
        end
        high_run++;
        prev = 1;
      end else begin
        if (prev) begin
          if (high_run != 1 && high_run != 2) timing_err++;
          if (collecting) begin
            got_bits = {got_bits[190:0], (high_run >= 2)};
            nbits++;
            if (nbits == 192) begin
              collecting = 0;
              if (armed) begin
                want = exp_frame(cur[7:0], cur[9:8]);
                checks++;
                if (got_bits !== want) begin
                  fails++;
                  $display("FAIL frame_data ch=%h mode=%0d: got=%h required=%h",
                           cur[7:0], cur[9:8], got_bits, want);
                end
                checks++;
                if (timing_err != 0) begin
                  fails++;
                  $display("FAIL frame_timing: got=%0d violations required=0", timing_err);
                end
                armed = 0; post_pending = 1; extra_bits = 0;
                frames_done++;
              end
            end
          end
          low_run = 0;
        end
        if (low_run < 1000000) low_run++;
        prev = 0;
      end
    end
  end

  task automatic wait_done(input int target);
    int n = 0;
    while (frames_done < target && n < 3000) begin @(posedge clk); n++; end
    if (frames_done < target) to_cnt++;
  endtask

  task automatic wait_popped();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) to_cnt++;
  endtask

  // Keep a window of 'need' cycles clear of a character step.
  task automatic wait_safe(input int need);
    int n = 0;
    while (((cyc % STEP) < 20 || (cyc % STEP) + need > STEP - 20) && n < 2 * STEP) begin
      @(posedge clk); n++;
    end
  endtask

  task automatic expect_frame(input logic [7:0] ch, input logic [1:0] md);
    int start;
    start = frames_done;
    exp_q.push_back({md, ch});
    wait_done(start + 1);
  endtask

  task automatic pulse_btn(input int len);
    @(negedge clk); btn_color = 1'b1;
    repeat (len) @(negedge clk);
    btn_color = 1'b0;
  endtask

  function automatic logic [7:0] char_now();
    return msg_char((cyc / STEP) % 8);
  endfunction

  logic [7:0] ch;
  int n0, w;

  initial begin
    btn_color = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;

    // First frames: 'H' in red, repeated
    expect_frame(8'h48, 2'd0);
    expect_frame(8'h48, 2'd0);

    // Press mid-frame: frame in flight stays red, next frame is green
    wait_safe(1600);
    ch = char_now();
    n0 = frames_done;
    exp_q.push_back({2'd0, ch});
    wait_popped();
    repeat (30) @(posedge clk);
    pulse_btn(1);
    wait_done(n0 + 1);
    expect_frame(ch, 2'd1);

    // Two presses inside the lockout count once: blue
    repeat (250) @(posedge clk);
    pulse_btn(1);
    repeat (50) @(posedge clk);
    pulse_btn(1);
    repeat (20) @(posedge clk);
    wait_safe(1000);
    expect_frame(char_now(), 2'd2);

    // Next accepted presses: white, then back to red
    repeat (250) @(posedge clk);
    pulse_btn(1);
    repeat (20) @(posedge clk);
    wait_safe(1000);
    expect_frame(char_now(), 2'd3);
    repeat (250) @(posedge clk);
    pulse_btn(1);
    repeat (20) @(posedge clk);
    wait_safe(1000);
    expect_frame(char_now(), 2'd0);

    // Held button gives exactly one increment: green
    repeat (250) @(posedge clk);
    pulse_btn(300);
    repeat (20) @(posedge clk);
    wait_safe(1000);
    expect_frame(char_now(), 2'd1);

    // Reset right after a rising edge of led_data
    w = 0;
    do begin @(posedge clk); #1; w++; end while (led_data !== 1'b1 && w < 3000);
    if (led_data !== 1'b1) to_cnt++;
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    expect_frame(8'h48, 2'd0);

    // Character steps: E L L O ' ' F A, then wrap to H
    for (int n = 1; n <= 8; n++) begin
      w = 0;
      while (cyc < n * STEP + 30 && w < 2 * STEP) begin @(posedge clk); w++; end
      expect_frame(msg_char(n % 8), 2'd0);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
